// File: rtl/seq_multiplier_8bit_if.sv
// Handshake and operand bus between the ALU and the sequential 8x8 multiplier.
// The master (ALU) issues start with operands; the slave (multiplier) returns
// busy, a one-cycle done pulse and the registered 16-bit product.
interface seq_multiplier_8bit_if;
  logic        start;
  logic [7:0]  multiplicand;
  logic [7:0]  multiplier;
  logic        busy;
  logic        done;
  logic [15:0] product;

  modport master (
    output start,
    output multiplicand,
    output multiplier,
    input  busy,
    input  done,
    input  product
  );

  modport slave (
    input  start,
    input  multiplicand,
    input  multiplier,
    output busy,
    output done,
    output product
  );
endinterface

// File: rtl/seq_multiplier_8bit.sv
// Multi-cycle unsigned 8x8 shift-and-add multiplier with a 16-bit product.
// Operands are latched on an accepted start; one partial-product step is
// taken per RUN cycle and the product register is loaded on the edge that
// enters DONE, where done pulses for a single cycle.
// Optional build macro MUL_EARLY_TERM_EN: leave RUN as soon as the remaining
// multiplier bits are all zero, shortening latency for small multipliers.
module seq_multiplier_8bit (
  input  logic                         clk,
  input  logic                         rst,
  seq_multiplier_8bit_if.slave         mif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q;
  state_t      state_d;

  logic [15:0] a_sh;
  logic [7:0]  b_sh;
  logic [15:0] acc;
  logic [2:0]  count;
  logic [15:0] product_q;

  logic [15:0] acc_next;
  logic [7:0]  b_sh_next;
  logic        last_step;

  // One shift-and-add step: conditional accumulate and the shifted multiplier.
  always_comb begin
    acc_next  = acc;
    b_sh_next = b_sh >> 1;
    if (b_sh[0]) begin
      acc_next = acc + a_sh;
    end
`ifdef MUL_EARLY_TERM_EN
    last_step = (count == 3'd7) || (b_sh_next == 8'd0);
`else
    last_step = (count == 3'd7);
`endif
  end

  // State register; reset discards any in-flight operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode; start is only looked at while idle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (mif.start) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (last_step) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath: operand latch, per-cycle step, product load on entry to DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh      <= 16'h0000;
      b_sh      <= 8'h00;
      acc       <= 16'h0000;
      count     <= 3'd0;
      product_q <= 16'h0000;
    end else begin
      case (state_q)
        IDLE: begin
          if (mif.start) begin
            a_sh  <= {8'h00, mif.multiplicand};
            b_sh  <= mif.multiplier;
            acc   <= 16'h0000;
            count <= 3'd0;
          end
        end
        RUN: begin
          acc   <= acc_next;
          a_sh  <= a_sh << 1;
          b_sh  <= b_sh_next;
          count <= count + 3'd1;
          if (last_step) begin
            product_q <= acc_next;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Outputs decode the registered state only, so no input reaches them combinationally.
  assign mif.busy    = (state_q != IDLE);
  assign mif.done    = (state_q == DONE);
  assign mif.product = product_q;

endmodule

// File: tb/tb_seq_multiplier_8bit.sv
// Directed bench for seq_multiplier_8bit: a vector table of operand pairs with
// hand-computed products and latencies, plus hand-written sequences for
// ignored start, mid-run reset and back-to-back issue.
module tb_seq_multiplier_8bit;

  logic clk;
  logic rst;

  seq_multiplier_8bit_if mif ();

  seq_multiplier_8bit dut (
    .clk (clk),
    .rst (rst),
    .mif (mif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] prod;
    int          lat_full;
    int          lat_early;
  } vec_t;

  int tests;
  int fails;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int pick_lat(input int full, input int early);
`ifdef MUL_EARLY_TERM_EN
    return early;
`else
    return full;
`endif
  endfunction

  // Called just after a negedge (cycle 0). Issues one operation and follows it
  // to one cycle past the expected done.
  task automatic run_op(input string name, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] exp_p, input int exp_lat);
    int got;
    int pulses;
    logic busy_ok;
    got = -1;
    pulses = 0;
    busy_ok = 1'b1;
    mif.start = 1'b1;
    mif.multiplicand = a;
    mif.multiplier = b;
    for (int c = 1; c <= exp_lat + 1; c++) begin
      @(negedge clk);
      if (c == 1) begin
        mif.start = 1'b0;
        mif.multiplicand = 8'($urandom);
        mif.multiplier = 8'($urandom);
      end
      if (mif.done === 1'b1) begin
        pulses++;
        if (got < 0) begin
          got = c;
          check({name, " product"}, 32'(mif.product), 32'(exp_p));
        end
      end
      if (c <= exp_lat && mif.busy !== 1'b1) busy_ok = 1'b0;
    end
    check({name, " done cycle"}, 32'(got), 32'(exp_lat));
    check({name, " done pulses"}, 32'(pulses), 32'd1);
    check({name, " busy during op"}, 32'(busy_ok), 32'd1);
    check({name, " busy after"}, 32'(mif.busy), 32'd0);
    check({name, " product held"}, 32'(mif.product), 32'(exp_p));
  endtask

  vec_t vecs[8];

  initial begin
    int lat;
    int pulses;
    tests = 0;
    fails = 0;

    vecs[0] = '{8'd13,  8'd11,  16'h008F, 9, 5};
    vecs[1] = '{8'd255, 8'd255, 16'hFE01, 9, 9};
    vecs[2] = '{8'd0,   8'd200, 16'h0000, 9, 9};
    vecs[3] = '{8'd200, 8'd3,   16'h0258, 9, 3};
    vecs[4] = '{8'd200, 8'd128, 16'h6400, 9, 9};
    vecs[5] = '{8'd1,   8'd0,   16'h0000, 9, 2};
    vecs[6] = '{8'd1,   8'd1,   16'h0001, 9, 2};
    vecs[7] = '{8'd3,   8'd5,   16'h000F, 9, 4};

    rst = 1'b1;
    mif.start = 1'b0;
    mif.multiplicand = 8'h00;
    mif.multiplier = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset busy", 32'(mif.busy), 32'd0);
    check("reset done", 32'(mif.done), 32'd0);
    check("reset product", 32'(mif.product), 32'h0);

    // Vector table
    for (int i = 0; i < 8; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].prod,
             pick_lat(vecs[i].lat_full, vecs[i].lat_early));
    end

    // Start reasserted mid-run with different operands is ignored
    lat = pick_lat(9, 5);
    pulses = 0;
    mif.start = 1'b1;
    mif.multiplicand = 8'd7;
    mif.multiplier = 8'd9;
    for (int c = 1; c <= 25; c++) begin
      @(negedge clk);
      if (mif.done === 1'b1) begin
        pulses++;
        check("ignored start done cycle", 32'(c), 32'(lat));
        check("ignored start product", 32'(mif.product), 32'h003F);
      end
      if (c == 4) begin
        mif.start = 1'b1;
        mif.multiplicand = 8'd1;
        mif.multiplier = 8'd1;
      end else begin
        mif.start = 1'b0;
      end
    end
    check("ignored start pulses", 32'(pulses), 32'd1);
    check("ignored start product held", 32'(mif.product), 32'h003F);

    // Reset in cycle 5 of a running operation
    pulses = 0;
    mif.start = 1'b1;
    mif.multiplicand = 8'd100;
    mif.multiplier = 8'd100;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      mif.start = 1'b0;
      if (mif.done === 1'b1) pulses++;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid reset busy", 32'(mif.busy), 32'd0);
    check("mid reset done", 32'(mif.done), 32'd0);
    check("mid reset product", 32'(mif.product), 32'h0);
    repeat (15) begin
      @(negedge clk);
      if (mif.done === 1'b1) pulses++;
    end
    check("mid reset no done", 32'(pulses), 32'd0);
    run_op("after reset", 8'd2, 8'd3, 16'h0006, pick_lat(9, 3));

    // Back-to-back issue with start held high
    lat = pick_lat(9, 4);
    pulses = 0;
    mif.start = 1'b1;
    mif.multiplicand = 8'd3;
    mif.multiplier = 8'd5;
    for (int c = 1; c <= 3 * (lat + 1); c++) begin
      @(negedge clk);
      if ((c % (lat + 1)) == lat) begin
        check($sformatf("b2b done c%0d", c), 32'(mif.done), 32'd1);
        check($sformatf("b2b product c%0d", c), 32'(mif.product), 32'h000F);
        pulses++;
      end else if (mif.done !== 1'b0) begin
        check($sformatf("b2b stray done c%0d", c), 32'(mif.done), 32'd0);
      end
    end
    mif.start = 1'b0;
    check("b2b pulses seen", 32'(pulses), 32'd3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
